// File: rtl/stack_datapath.sv
// rtl/stack_datapath.sv - multicycle stack-machine datapath
// PC/IR/MDR/A/B registers, ALU with output register, bounded stack with sticky error flags.
module stack_datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               alu_op,
  input  logic                     pc_write_uncond,
  input  logic                     pc_write_cond,
  input  logic                     i_or_d,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic                     ir_write,
  input  logic                     m_to_s,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     tos,
  input  logic                     ld_a,
  input  logic                     ld_b,
  input  logic                     src_a,
  input  logic                     src_b,
  input  logic                     pc_src,
  input  logic                     err_clr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_rd,
  output logic                     mem_wr,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [DATA_W-ADDR_W-1:0] opc,
  output logic                     zero,
  output logic                     stack_full,
  output logic                     stack_empty,
  output logic                     stack_ovf,
  output logic                     stack_unf
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int OW = DATA_W - ADDR_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d, mdr_q, mdr_d, a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] alu_q, alu_d, sout_q, sout_d;
  logic              zero_q, zero_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] stack_q [DEPTH];

  logic [DATA_W-1:0] alu_a, alu_b, alu_res, din;
  logic [IW-1:0]     wr_idx, top_idx;
  logic              wr_en, is_empty, is_full, pc_write;

  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == FULL_CNT);
  // Wraps correctly at count == DEPTH, where the low bits are zero.
  assign top_idx  = cnt_q[IW-1:0] - IW'(1);

  always_comb begin
    alu_a = src_a ? {{OW{1'b0}}, pc_q} : a_q;
    alu_b = src_b ? DATA_W'(1) : b_q;
    case (alu_op)
      2'b00:   alu_res = alu_a + alu_b;
      2'b01:   alu_res = alu_a - alu_b;
      2'b10:   alu_res = alu_a & alu_b;
      default: alu_res = ~alu_a;
    endcase
  end

  always_comb begin
    pc_write = pc_write_uncond | (pc_write_cond & zero_q);
    pc_d     = pc_q;
    if (pc_write) pc_d = pc_src ? ir_q[ADDR_W-1:0] : alu_res[ADDR_W-1:0];
    ir_d   = ir_write ? mem_rdata : ir_q;
    mdr_d  = mem_rdata;
    a_d    = ld_a ? sout_q : a_q;
    b_d    = ld_b ? sout_q : b_q;
    alu_d  = alu_res;
    zero_d = (sout_q == '0);
  end

  // tos reads the current top before any replace/pop of this cycle lands.
  always_comb begin
    din    = m_to_s ? mdr_q : alu_q;
    cnt_d  = cnt_q;
    sout_d = sout_q;
    wr_en  = 1'b0;
    wr_idx = cnt_q[IW-1:0];
    ovf_d  = ovf_q & ~err_clr;
    unf_d  = unf_q & ~err_clr;
    if (tos) begin
      if (is_empty) unf_d = 1'b1;
      else          sout_d = stack_q[top_idx];
    end
    if (push && pop) begin
      if (is_empty) unf_d = 1'b1;
      else begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end
    end else if (push) begin
      if (is_full) ovf_d = 1'b1;
      else begin
        wr_en = 1'b1;
        cnt_d = cnt_q + CW'(1);
      end
    end else if (pop) begin
      if (is_empty) unf_d = 1'b1;
      else          cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= '0;
      ir_q   <= '0;
      mdr_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      alu_q  <= '0;
      sout_q <= '0;
      zero_q <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      mdr_q  <= mdr_d;
      a_q    <= a_d;
      b_q    <= b_d;
      alu_q  <= alu_d;
      sout_q <= sout_d;
      zero_q <= zero_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) stack_q[wr_idx] <= din;
  end

  assign mem_addr    = i_or_d ? ir_q[ADDR_W-1:0] : pc_q;
  assign mem_wdata   = a_q;
  assign mem_rd      = mem_read;
  assign mem_wr      = mem_write;
  assign opc         = ir_q[DATA_W-1:ADDR_W];
  assign zero        = zero_q;
  assign stack_full  = is_full;
  assign stack_empty = is_empty;
  assign stack_ovf   = ovf_q;
  assign stack_unf   = unf_q;
endmodule

// File: tb/tb_stack_datapath.sv
// tb/tb_stack_datapath.sv - directed and random checks of stack_datapath
// Reference model keeps the stack as a queue and registers as plain variables.
module tb_stack_datapath;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 8;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] alu_op;
  logic pc_write_uncond, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic m_to_s, push, pop, tos, ld_a, ld_b, src_a, src_b, pc_src, err_clr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic mem_rd, mem_wr;
  logic [DATA_W-ADDR_W-1:0] opc;
  logic zero, stack_full, stack_empty, stack_ovf, stack_unf;

  int n_cmp = 0;
  int n_err = 0;

  logic [ADDR_W-1:0] m_pc;
  logic [DATA_W-1:0] m_ir, m_mdr, m_a, m_b, m_alu, m_sout;
  logic m_zero, m_ovf, m_unf;
  logic [DATA_W-1:0] mq[$];

  stack_datapath #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .alu_op(alu_op),
    .pc_write_uncond(pc_write_uncond), .pc_write_cond(pc_write_cond),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .m_to_s(m_to_s), .push(push), .pop(pop), .tos(tos),
    .ld_a(ld_a), .ld_b(ld_b), .src_a(src_a), .src_b(src_b), .pc_src(pc_src),
    .err_clr(err_clr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .opc(opc),
    .zero(zero), .stack_full(stack_full), .stack_empty(stack_empty),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_ctl();
    {alu_op, pc_write_uncond, pc_write_cond, i_or_d, mem_read, mem_write, ir_write} = '0;
    {m_to_s, push, pop, tos, ld_a, ld_b, src_a, src_b, pc_src, err_clr, rst} = '0;
  endtask

  task automatic set_all_ctl();
    alu_op = 2'b11;
    {pc_write_uncond, pc_write_cond, i_or_d, mem_read, mem_write, ir_write} = '1;
    {m_to_s, push, pop, tos, ld_a, ld_b, src_a, src_b, pc_src, err_clr} = '1;
  endtask

  task automatic model_step();
    logic [DATA_W-1:0] x, y, r, din, n_sout;
    logic n_ovf, n_unf;
    if (rst) begin
      m_pc = '0; m_ir = '0; m_mdr = '0; m_a = '0; m_b = '0; m_alu = '0; m_sout = '0;
      m_zero = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      mq.delete();
      return;
    end
    x = src_a ? DATA_W'(m_pc) : m_a;
    y = src_b ? DATA_W'(1) : m_b;
    case (alu_op)
      2'd0:    r = x + y;
      2'd1:    r = x - y;
      2'd2:    r = x & y;
      default: r = ~x;
    endcase
    din    = m_to_s ? m_mdr : m_alu;
    n_sout = m_sout;
    n_ovf  = err_clr ? 1'b0 : m_ovf;
    n_unf  = err_clr ? 1'b0 : m_unf;
    if (tos) begin
      if (mq.size() == 0) n_unf = 1'b1;
      else n_sout = mq[mq.size()-1];
    end
    if (push && pop) begin
      if (mq.size() == 0) n_unf = 1'b1;
      else mq[mq.size()-1] = din;
    end else if (push) begin
      if (mq.size() == DEPTH) n_ovf = 1'b1;
      else mq.push_back(din);
    end else if (pop) begin
      if (mq.size() == 0) n_unf = 1'b1;
      else void'(mq.pop_back());
    end
    if (pc_write_uncond || (pc_write_cond && m_zero))
      m_pc = pc_src ? m_ir[ADDR_W-1:0] : r[ADDR_W-1:0];
    m_zero = (m_sout == 0);
    if (ld_a) m_a = m_sout;
    if (ld_b) m_b = m_sout;
    m_sout = n_sout;
    m_alu  = r;
    m_mdr  = mem_rdata;
    if (ir_write) m_ir = mem_rdata;
    m_ovf = n_ovf;
    m_unf = n_unf;
  endtask

  task automatic check_all();
    chk("mem_addr", 32'(mem_addr), 32'(i_or_d ? m_ir[ADDR_W-1:0] : m_pc));
    chk("mem_wdata", 32'(mem_wdata), 32'(m_a));
    chk("opc", 32'(opc), 32'(m_ir[DATA_W-1:ADDR_W]));
    chk("zero", 32'(zero), 32'(m_zero));
    chk("stack_full", 32'(stack_full), 32'(mq.size() == DEPTH));
    chk("stack_empty", 32'(stack_empty), 32'(mq.size() == 0));
    chk("stack_ovf", 32'(stack_ovf), 32'(m_ovf));
    chk("stack_unf", 32'(stack_unf), 32'(m_unf));
    chk("mem_rd", 32'(mem_rd), 32'(mem_read));
    chk("mem_wr", 32'(mem_wr), 32'(mem_write));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic mdr_push(input logic [DATA_W-1:0] val);
    clr_ctl();
    mem_rdata = val;
    tick();
    m_to_s = 1'b1;
    push   = 1'b1;
    tick();
    clr_ctl();
  endtask

  task automatic do_reset();
    clr_ctl();
    rst = 1'b1;
    tick();
    clr_ctl();
  endtask

  initial begin
    mem_rdata = 8'h5a;
    set_all_ctl();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_opc", 32'(opc), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_empty", 32'(stack_empty), 1);
    chk("rst_full", 32'(stack_full), 0);
    chk("rst_flags", 32'({stack_ovf, stack_unf, zero}), 0);

    clr_ctl();
    mem_rdata = 8'b101_00110;
    mem_read = 1'b1; ir_write = 1'b1; src_a = 1'b1; src_b = 1'b1; pc_write_uncond = 1'b1;
    tick();
    chk("fetch_opc", 32'(opc), 3'b101);
    chk("fetch_pc", 32'(mem_addr), 1);

    mdr_push(8'd5);
    mdr_push(8'd3);
    tos = 1'b1; tick(); clr_ctl();
    ld_b = 1'b1; pop = 1'b1; tick(); clr_ctl();
    tos = 1'b1; tick(); clr_ctl();
    ld_a = 1'b1; pop = 1'b1; tick(); clr_ctl();
    chk("sub_empty", 32'(stack_empty), 1);
    alu_op = 2'b01; tick(); clr_ctl();
    push = 1'b1; tick(); clr_ctl();
    chk("sub_count1", 32'(stack_empty), 0);
    tos = 1'b1; tick(); clr_ctl();
    ld_a = 1'b1; tick(); clr_ctl();
    chk("sub_result", 32'(mem_wdata), 2);
    pop = 1'b1; tick(); clr_ctl();
    chk("sub_pop_empty", 32'(stack_empty), 1);

    mdr_push(8'hff);
    tos = 1'b1; tick(); clr_ctl();
    ld_a = 1'b1; tick(); clr_ctl();
    src_b = 1'b1; tick(); clr_ctl();
    push = 1'b1; tick(); clr_ctl();
    tos = 1'b1; tick(); clr_ctl();
    tick();
    chk("add_wrap_zero", 32'(zero), 1);

    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      mdr_push(DATA_W'(i + 1));
      if (i == DEPTH - 1) begin
        chk("ovf_full8", 32'(stack_full), 1);
        chk("ovf_none8", 32'(stack_ovf), 0);
      end
    end
    chk("ovf_full9", 32'(stack_full), 1);
    chk("ovf_set", 32'(stack_ovf), 1);
    err_clr = 1'b1; tick(); clr_ctl();
    chk("ovf_clr", 32'(stack_ovf), 0);
    tos = 1'b1; tick(); clr_ctl();
    ld_a = 1'b1; tick(); clr_ctl();
    chk("ovf_top", 32'(mem_wdata), DEPTH);

    do_reset();
    pop = 1'b1; tick(); clr_ctl();
    chk("unf_set", 32'(stack_unf), 1);
    chk("unf_empty", 32'(stack_empty), 1);
    err_clr = 1'b1; pop = 1'b1; tick(); clr_ctl();
    chk("unf_clr_loses", 32'(stack_unf), 1);
    err_clr = 1'b1; tick(); clr_ctl();
    chk("unf_clr", 32'(stack_unf), 0);
    mdr_push(8'h11);
    mdr_push(8'h22);
    mem_rdata = 8'h33; tick();
    m_to_s = 1'b1; push = 1'b1; pop = 1'b1; tick(); clr_ctl();
    tos = 1'b1; tick(); clr_ctl();
    ld_a = 1'b1; tick(); clr_ctl();
    chk("pushpop_top", 32'(mem_wdata), 8'h33);
    pop = 1'b1; tick(); tick(); clr_ctl();
    chk("pushpop_count2", 32'({stack_empty, stack_unf}), 2'b10);

    do_reset();
    mem_rdata = 8'd17; ir_write = 1'b1; tick(); clr_ctl();
    mdr_push(8'd0);
    tos = 1'b1; tick(); clr_ctl();
    tick();
    pc_write_cond = 1'b1; pc_src = 1'b1; tick(); clr_ctl();
    chk("br_taken", 32'(mem_addr), 17);
    mem_rdata = 8'd9; ir_write = 1'b1; tick(); clr_ctl();
    mdr_push(8'd4);
    tos = 1'b1; tick(); clr_ctl();
    tick();
    pc_write_cond = 1'b1; pc_src = 1'b1; tick(); clr_ctl();
    chk("br_not_taken", 32'(mem_addr), 17);

    for (int n = 0; n < 400; n++) begin
      {pc_write_uncond, pc_write_cond, i_or_d, mem_read, mem_write, ir_write} = 6'($urandom);
      {m_to_s, push, pop, tos, ld_a, ld_b, src_a, src_b, pc_src, err_clr} = 10'($urandom);
      alu_op    = 2'($urandom);
      mem_rdata = DATA_W'($urandom);
      if ($urandom_range(0, 3) == 0) mem_rdata = '0;
      rst = ($urandom_range(0, 47) == 0);
      tick();
    end

    clr_ctl();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/stack_datapath.md
Name: stack_datapath

Overview:
Parametrised datapath for the multicycle stack-machine CPU: PC, IR, MDR, A/B operand registers, ALU plus ALU output register, and a bounded hardware stack with full/empty detection and sticky error flags. Driven cycle-by-cycle by the external controller through decoded control inputs; returns opcode and status. Memory is external, reached through a single-port interface.

Parameters:
DATA_W, 8, datapath/word width; instruction = {opcode, address}
ADDR_W, 5, memory address and PC width; DATA_W-ADDR_W >= 2 required
DEPTH, 8, stack entries; power of two, >= 2

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
alu_op  in  2  00 add, 01 sub, 10 and, 11 not A
pc_write_uncond  in  1  unconditional PC load
pc_write_cond  in  1  PC load if zero flag set
i_or_d  in  1  memory address select: 0 PC, 1 IR[ADDR_W-1:0]
mem_read  in  1  memory read strobe (passed to mem_rd)
mem_write  in  1  memory write strobe (passed to mem_wr)
ir_write  in  1  load IR from mem_rdata
m_to_s  in  1  stack push source: 0 ALU reg, 1 MDR
push  in  1  push to stack
pop  in  1  pop from stack
tos  in  1  load stack output register from top entry
ld_a  in  1  load A from stack output register
ld_b  in  1  load B from stack output register
src_a  in  1  ALU A: 0 A reg, 1 zero-extended PC
src_b  in  1  ALU B: 0 B reg, 1 constant 1
pc_src  in  1  PC input: 0 ALU result[ADDR_W-1:0], 1 IR[ADDR_W-1:0]
err_clr  in  1  clear sticky stack error flags
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  write data = A reg
mem_rd  out  1  = mem_read
mem_wr  out  1  = mem_write
mem_rdata  in  DATA_W  read data, combinational, valid same cycle as mem_rd
opc  out  DATA_W-ADDR_W  IR[DATA_W-1:ADDR_W]
zero  out  1  registered zero flag
stack_full  out  1  occupancy == DEPTH
stack_empty  out  1  occupancy == 0
stack_ovf  out  1  sticky push-on-full flag
stack_unf  out  1  sticky pop-on-empty / tos-on-empty flag

Behaviour:
- All state updates on rising clk. rst (sync) clears PC, IR, MDR, A, B, ALU reg, stack output reg, zero, occupancy count, ovf, unf; stack array contents not cleared. After reset: opc=0, mem_addr=0, stack_empty=1, stack_full=0, zero=0.
- rst mid-operation overrides every control input in that cycle.
- pc_write = pc_write_uncond | (pc_write_cond & zero); PC <= pc_src ? IR addr : ALU result[ADDR_W-1:0].
- MDR loads mem_rdata every cycle; IR loads mem_rdata only when ir_write.
- ALU combinational, width DATA_W, results wrap modulo 2^DATA_W; sub = A-B two's complement; PC zero-extended when src_a=1. ALU reg captures result every cycle.
- Stack: occupancy count 0..DEPTH (clog2(DEPTH)+1 bits). Push writes din (m_to_s mux) at index count, count+1. Pop count-1. tos: stack output reg <= entry[count-1].
- push & pop same cycle with count>=1: top entry replaced by din, count unchanged. With count==0: treated as pop on empty (unf set, no write).
- Push when full (no pop): no write, count unchanged, stack_ovf <= 1. Pop when empty: count unchanged, stack_unf <= 1. tos when empty: output reg unchanged, stack_unf <= 1.
- tos with pop same cycle: output reg takes pre-pop top (read-before-pop).
- err_clr clears ovf/unf; a new error in the same cycle wins (flag stays 1).
- zero <= (stack output reg == 0), registered every cycle (one-cycle lag behind output reg).
- A/B load from stack output reg when ld_a/ld_b.
- stack_full/stack_empty combinational from count.

Test Plan:
- Reset: assert rst 2 cycles with all controls high -> PC=0, opc=0, stack_empty=1, ovf=unf=0, zero=0.
- Fetch: mem_rdata=8'b101_00110, mem_read, ir_write, src_a=1, src_b=1, alu_op=00, pc_write_uncond -> next cycle opc=3'b101, PC=1.
- Push/pop ALU: push MDR values 5 then 3; tos, ld_b, pop; tos, ld_a, pop; alu_op=01, next cycle m_to_s=0, push -> top entry=2, count=1; add of 8'hFF+1 yields 0 (wrap).
- Overflow: DEPTH=8, 9 pushes -> stack_full after 8th, 9th leaves count=8, ovf=1; err_clr -> ovf=0.
- Underflow: pop on empty -> unf=1, count=0; push&pop at count=2 -> count=2, top replaced.
- Conditional branch: top entry 0, tos, wait one cycle, pc_write_cond, pc_src=1, IR addr=5'd17 -> PC=17; top entry 4 -> PC unchanged.
